line_win_checker: RTL
=====================

# line_win_checker

Parametrised five-in-a-row win detector for the board-logic path. It replaces the four chained per-direction checkers with one FSM that scans horizontal, vertical, diagonal and anti-diagonal lines in turn. It reads the board RAM through a 1-cycle-latency read port and reports whether the stone just placed at `pointer` completes a run of `WIN_LEN`. It sits between the move-commit logic and the game-state controller.

## Interface
- `BOARD_N`, 16: board side length, in cells; must be a power of two, 8 to 16.
- `WIN_LEN`, 5: required run length, 3 to 8.
- `DIR_MASK`, 4'b1111: enable bit per direction; bit0 horizontal, bit1 vertical, bit2 diagonal (down-right), bit3 anti-diagonal (up-right).
- `COORD_W` is derived as log2(`BOARD_N`) and is not a top-level override.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a check; sampled only in IDLE.
- `pointer`  in  2*COORD_W  placed cell as {row, col}.
- `chess`  in  2  stone colour to match; 2'b00 is empty.
- `rd_addr`  out  2*COORD_W  board RAM read address {row, col}.
- `rd_data`  in  2  cell content, valid the cycle after `rd_addr`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `win`  out  1  result; held until the next accepted `start`.
- `win_dir`  out  2  direction index of the winning line; 0 when `win`=0.
- `win_start`  out  2*COORD_W  address of the first cell of the winning run; 0 when `win`=0.

## Operation
- States: IDLE, SETUP, SCAN, DRAIN, NEXT, DONE.
- **IDLE**
  - On `start`=1, latch `pointer` and `chess`, and clear `win`, `win_dir` and `win_start`.
  - If `chess`=0, go to DONE with no reads.
  - Otherwise go to SETUP with the direction index at the lowest enabled bit.
  - If `DIR_MASK`=0, go straight to DONE.
- **SETUP**, one cycle per direction. The step vector (dr,dc) is (0,+1), (+1,0), (+1,+1) or (-1,+1).
  - back = min(WIN_LEN-1, cells available in direction -(dr,dc)).
  - fwd = min(WIN_LEN-1, cells available in direction +(dr,dc)).
  - Line start = pointer − back·(dr,dc).
  - Length L = back + fwd + 1, in the range 1 to 2·WIN_LEN−1.
  - Clear the run counter and the issue counter.
- **SCAN**
  - Each cycle, drive `rd_addr` with the current cell, step the cell by (dr,dc) and increment the issue counter.
  - In the same cycle, compare the `rd_data` returned for the previous cell (from the 2nd SCAN cycle onward).
  - After L issues, go to DRAIN.
- **Compare rule**
  - `rd_data`==chess: run+1. When run = 1, record that cell as the candidate start.
  - Otherwise: run=0.
  - When run reaches `WIN_LEN`: set `win`=1, set `win_dir`, set `win_start` to the candidate, then go to DONE immediately. Any outstanding read is discarded.
- **DRAIN**: compare the last cell, then go to NEXT.
- **NEXT**: advance to the next enabled direction and enter SETUP; if none remain, go to DONE.
- **DONE**: `done`=1 for one cycle, `busy`=0, then IDLE.
- **Arithmetic**
  - Coordinates are unsigned COORD_W-bit values.
  - The back/fwd clamps guarantee that no step wraps past an edge. Wrap-around must never occur; the bench asserts this.
  - The run counter is ceil(log2(WIN_LEN+1)) bits.
- **Boundary behaviour**
  - `start` while busy is ignored.
  - A run longer than `WIN_LEN` reports at the `WIN_LEN`-th cell.
  - A run touching the board edge is counted, including the edge cell.
- **Reset**
  - `reset`=1 at any point, including mid-scan, returns to IDLE next edge.
  - Reset values: `busy`=0, `done`=0, `win`=0, `win_dir`=0, `win_start`=0, `rd_addr`=0.

## Timing
- `start` is accepted at cycle 0 and SETUP runs at cycle 1.
- Each enabled direction costs L+2 cycles.
- No win: `done` is asserted at cycle 1 + Σ(L_d+2).
- Win: `done` follows the winning compare cycle by one cycle.
- `rd_addr` is registered. `rd_data` is sampled exactly one cycle after its address.
- Results are valid in the `done` cycle and hold until the next accepted `start`.

## Structure
- Shared package `gomoku_pkg`:
  - cell encoding: EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10;
  - direction enum: DIR_H=0, DIR_V=1, DIR_D=2, DIR_A=3, plus the step-vector constants;
  - state enum.
- Sub-module `line_span_calc`: combinational; maps (pointer, dir) to (line start, L). It is instantiated once and muxed by the direction index.

## Test plan
- Empty board, pointer=(8,8), chess=BLACK: L=9 in all four directions; `done` at cycle 45, `win`=0, 36 reads, each address checked.
- Corner pointer=(0,0), empty board: L=5,5,5,1; `done` at cycle 25, `win`=0, and no `rd_addr` ever wraps.
- BLACK at (3,2) through (3,6), pointer=(3,4): `win`=1, `win_dir`=0, `win_start`=(3,2); `done` one cycle after the 5th matching compare; no vertical reads are issued.
- WHITE on the anti-diagonal (10,5), (9,6), (8,7), (7,8), (6,9), pointer=(8,7), chess=WHITE: `win`=1, `win_dir`=3, `win_start`=(10,5).
- Four BLACK plus one WHITE breaking the horizontal run, with DIR_MASK=4'b0001: `win`=0 and `done` after a single direction. Also: `start` with chess=0 gives `done` at cycle 1 with no reads.
- Assert `reset` in the middle of SCAN: the next cycle is IDLE with all outputs 0; a following `start` completes normally. A `start` pulse while busy is ignored.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared board-logic definitions for the gomoku datapath.
//   cell_e      : board cell encoding (EMPTY / BLACK / WHITE)
//   dir_e       : line direction index (H, V, D = down-right, A = up-right)
//   STEP_DR/DC  : per-direction step vector, indexed by dir_e
//   state_e     : line_win_checker FSM states
//   pick_dir()  : lowest enabled direction at or above a given index
package gomoku_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_e;

    typedef enum logic [1:0] {
        DIR_H = 2'd0,
        DIR_V = 2'd1,
        DIR_D = 2'd2,
        DIR_A = 2'd3
    } dir_e;

    // Row / column step per direction; the anti-diagonal climbs rows.
    localparam int STEP_DR [4] = '{0, 1, 1, -1};
    localparam int STEP_DC [4] = '{1, 0, 1,  1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } dir_pick_t;

    function automatic dir_pick_t pick_dir(input logic [3:0] mask, input int from);
        dir_pick_t p;
        p.valid = 1'b0;
        p.dir   = DIR_H;
        // Descending walk so the lowest qualifying index is the one kept.
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && i >= from) begin
                p.valid = 1'b1;
                p.dir   = dir_e'(2'(i));
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/line_span_calc.sv
// Combinational span calculator for one scan direction.
//   pointer    in  {row, col} of the placed cell
//   dir        in  direction index
//   line_start out {row, col} of the first cell to read
//   line_len   out number of cells to read (1 .. 2*WIN_LEN-1)
// The span reaches at most WIN_LEN-1 cells either side of the pointer and is
// clipped at the board edge, so walking it never wraps a coordinate.
module line_span_calc
    import gomoku_pkg::*;
#(
    parameter  int BOARD_N = 16,
    parameter  int WIN_LEN = 5,
    localparam int COORD_W = $clog2(BOARD_N),
    localparam int LEN_W   = $clog2(2 * WIN_LEN)
) (
    input  logic [2*COORD_W-1:0] pointer,
    input  dir_e                 dir,
    output logic [2*COORD_W-1:0] line_start,
    output logic [LEN_W-1:0]     line_len
);

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Cells available from pos when moving by step along one axis.
    function automatic int avail(input int pos, input int step);
        if (step > 0) return BOARD_N - 1 - pos;
        if (step < 0) return pos;
        return WIN_LEN - 1;
    endfunction

    always_comb begin
        int row, col, dr, dc, back, fwd;
        row  = int'(pointer[2*COORD_W-1:COORD_W]);
        col  = int'(pointer[COORD_W-1:0]);
        dr   = STEP_DR[int'(dir)];
        dc   = STEP_DC[int'(dir)];
        back = imin(WIN_LEN - 1, imin(avail(row, -dr), avail(col, -dc)));
        fwd  = imin(WIN_LEN - 1, imin(avail(row, dr), avail(col, dc)));
        line_start = {COORD_W'(row - back * dr), COORD_W'(col - back * dc)};
        line_len   = LEN_W'(back + fwd + 1);
    end

endmodule

// File: rtl/line_win_checker.sv
// Five-in-a-row win detector. Scans the enabled directions through the placed
// cell, reading the board RAM through a 1-cycle-latency port.
//   clk, reset         clock, synchronous active-high reset
//   start              request a check (sampled in IDLE only)
//   pointer, chess     placed cell {row, col} and colour to match
//   rd_addr, rd_data   board RAM read port (data one cycle after address)
//   busy, done         busy while scanning; one-cycle completion pulse
//   win, win_dir,      result, held until the next accepted start
//   win_start
module line_win_checker
    import gomoku_pkg::*;
#(
    parameter  int         BOARD_N  = 16,
    parameter  int         WIN_LEN  = 5,
    parameter  logic [3:0] DIR_MASK = 4'b1111,
    localparam int         COORD_W  = $clog2(BOARD_N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*COORD_W-1:0] pointer,
    input  logic [1:0]           chess,
    output logic [2*COORD_W-1:0] rd_addr,
    input  logic [1:0]           rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 win,
    output logic [1:0]           win_dir,
    output logic [2*COORD_W-1:0] win_start
);

    localparam int AW    = 2 * COORD_W;
    localparam int LEN_W = $clog2(2 * WIN_LEN);
    localparam int RUN_W = $clog2(WIN_LEN + 1);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [1:0]       chess_q, chess_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;     // doubles as the scan cursor
    logic [AW-1:0]    prev_addr_q, prev_addr_d; // address whose data is on rd_data
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_q, issue_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [AW-1:0]    cand_q, cand_d;
    logic             win_q, win_d;
    dir_e             win_dir_q, win_dir_d;
    logic [AW-1:0]    win_start_q, win_start_d;

    dir_pick_t        first_pick, nxt_pick;
    dir_e             span_dir;
    logic [AW-1:0]    span_start;
    logic [LEN_W-1:0] span_len;
    logic [LEN_W-1:0] issue_inc;
    logic [RUN_W-1:0] run_inc;
    logic             cmp_valid, cmp_hit, win_now;

    function automatic logic [AW-1:0] step_cell(input logic [AW-1:0] c, input dir_e d);
        int r, k;
        r = int'(c[AW-1:COORD_W]) + STEP_DR[int'(d)];
        k = int'(c[COORD_W-1:0]) + STEP_DC[int'(d)];
        return {COORD_W'(r), COORD_W'(k)};
    endfunction

    assign first_pick = pick_dir(DIR_MASK, 0);
    assign nxt_pick   = pick_dir(DIR_MASK, int'(dir_q) + 1);

    // NEXT doubles as the setup cycle of the following direction, so every
    // direction costs exactly L+2 cycles (setup, L issues, drain).
    assign span_dir = (state_q == S_NEXT) ? nxt_pick.dir : dir_q;

    line_span_calc #(
        .BOARD_N (BOARD_N),
        .WIN_LEN (WIN_LEN)
    ) u_span (
        .pointer    (ptr_q),
        .dir        (span_dir),
        .line_start (span_start),
        .line_len   (span_len)
    );

    // Data for the cell issued last cycle is compared now; the first SCAN
    // cycle has nothing outstanding yet.
    assign issue_inc = issue_q + LEN_W'(1);
    assign run_inc   = run_q + RUN_W'(1);
    assign cmp_valid = (state_q == S_SCAN && issue_q != '0) || state_q == S_DRAIN;
    assign cmp_hit   = cmp_valid && (rd_data == chess_q);
    assign win_now   = cmp_hit && (run_inc == RUN_W'(WIN_LEN));

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignment so every flop samples
        // the pre-edge value of its inputs regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_H;
            ptr_q       <= '0;
            chess_q     <= '0;
            rd_addr_q   <= '0;
            prev_addr_q <= '0;
            len_q       <= '0;
            issue_q     <= '0;
            run_q       <= '0;
            cand_q      <= '0;
            win_q       <= 1'b0;
            win_dir_q   <= DIR_H;
            win_start_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            ptr_q       <= ptr_d;
            chess_q     <= chess_d;
            rd_addr_q   <= rd_addr_d;
            prev_addr_q <= prev_addr_d;
            len_q       <= len_d;
            issue_q     <= issue_d;
            run_q       <= run_d;
            cand_q      <= cand_d;
            win_q       <= win_d;
            win_dir_q   <= win_dir_d;
            win_start_q <= win_start_d;
        end
    end

    always_comb begin
        // NOTE: every signal takes its hold value first, so no branch can leave
        // one unassigned and infer a latch.
        state_d     = state_q;
        dir_d       = dir_q;
        ptr_d       = ptr_q;
        chess_d     = chess_q;
        rd_addr_d   = rd_addr_q;
        prev_addr_d = rd_addr_q;
        len_d       = len_q;
        issue_d     = issue_q;
        run_d       = run_q;
        cand_d      = cand_q;
        win_d       = win_q;
        win_dir_d   = win_dir_q;
        win_start_d = win_start_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d       = pointer;
                    chess_d     = chess;
                    win_d       = 1'b0;
                    win_dir_d   = DIR_H;
                    win_start_d = '0;
                    dir_d       = first_pick.dir;
                    if (chess == EMPTY || !first_pick.valid) state_d = S_DONE;
                    else                                     state_d = S_SETUP;
                end
            end
            S_SETUP, S_NEXT: begin
                if (state_q == S_NEXT) dir_d = nxt_pick.dir;
                rd_addr_d = span_start;
                len_d     = span_len;
                issue_d   = '0;
                run_d     = '0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                issue_d = issue_inc;
                // Hold the cursor on the last cell so it never steps off the board.
                if (issue_inc == len_q) state_d = S_DRAIN;
                else                    rd_addr_d = step_cell(rd_addr_q, dir_q);
            end
            S_DRAIN: state_d = nxt_pick.valid ? S_NEXT : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cmp_valid) begin
            if (cmp_hit) begin
                run_d = run_inc;
                if (run_q == '0) cand_d = prev_addr_q;
                if (win_now) begin
                    win_d       = 1'b1;
                    win_dir_d   = dir_q;
                    win_start_d = cand_q;
                    state_d     = S_DONE;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
        done = (state_q == S_DONE);
    end

    assign rd_addr   = rd_addr_q;
    assign win       = win_q;
    assign win_dir   = win_dir_q;
    assign win_start = win_start_q;

endmodule
